// File: rtl/memory_access_stage_pkg.sv
// Shared types for the memory access stage: control bundle, FSM states,
// funct3 size/sign encodings and the misalignment predicate.
package memory_access_stage_pkg;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_read;
    logic mem_write;
  } control_type;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_type;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Low two funct3 bits carry the access size for both loads and stores.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/memory_access_stage_load_store_align.sv
// Combinational byte-lane logic: store strobe/data replication and
// load extraction with sign or zero extension.
import memory_access_stage_pkg::*;

module memory_access_stage_load_store_align (
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_load_word,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_unsigned;

  assign w_half     = i_offset[1] ? i_load_word[31:16] : i_load_word[15:0];
  assign w_unsigned = i_funct3[2];

  always_comb begin
    w_byte = i_load_word[7:0];
    case (i_offset)
      2'd0: w_byte = i_load_word[7:0];
      2'd1: w_byte = i_load_word[15:8];
      2'd2: w_byte = i_load_word[23:16];
      2'd3: w_byte = i_load_word[31:24];
      default: w_byte = i_load_word[7:0];
    endcase
  end

  // Half accesses use only offset[1]; word accesses always use lane 0.
  always_comb begin
    o_wstrb     = 4'b1111;
    o_wdata     = i_store_data;
    o_load_data = i_load_word;
    case (i_funct3[1:0])
      2'b00: begin
        o_wstrb     = 4'b0001 << i_offset;
        o_wdata     = {4{i_store_data[7:0]}};
        o_load_data = w_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      end
      2'b01: begin
        o_wstrb     = 4'b0011 << {i_offset[1], 1'b0};
        o_wdata     = {2{i_store_data[15:0]}};
        o_load_data = w_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      end
      default: begin
        o_wstrb     = 4'b1111;
        o_wdata     = i_store_data;
        o_load_data = i_load_word;
      end
    endcase
  end

endmodule

// File: rtl/memory_access_stage.sv
// Memory access pipeline stage: issues loads/stores over a valid/ready data
// port, stalls upstream while busy. Optional macro: MISALIGN_TRAP_EN.
import memory_access_stage_pkg::*;

module memory_access_stage #(
  parameter int MAX_WAIT = 255
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [31:0]   alu_data_in,
  input  logic [31:0]   memory_data_in,
  input  logic [2:0]    funct3_in,
  input  control_type   control_in,
  output control_type   control_out,
  output logic [31:0]   alu_data_out,
  output logic [31:0]   memory_data_out,
  output logic          stall,
  output logic          bus_error,
  output logic          dmem_req_valid,
  input  logic          dmem_req_ready,
  output logic [31:0]   dmem_addr,
  output logic          dmem_we,
  output logic [3:0]    dmem_wstrb,
  output logic [31:0]   dmem_wdata,
  input  logic          dmem_rsp_valid,
  input  logic [31:0]   dmem_rdata,
`ifdef MISALIGN_TRAP_EN
  output logic          misaligned_fault,
`endif
  output mem_state_type o_dbg_state
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_WAIT_C = CW'(MAX_WAIT);

  // Request side holds dmem_req_valid with addr/we/wstrb/wdata stable until
  // dmem_req_ready is seen on a rising edge; a response is a single cycle of
  // dmem_rsp_valid, accepted in REQ (with the handshake) or in WAIT.

  mem_state_type r_state, w_state_nx;
  logic [CW-1:0] r_count, w_count_nx;
  logic [31:0]   r_addr, w_addr_nx;
  logic [31:0]   r_sdata, w_sdata_nx;
  logic [2:0]    r_f3, w_f3_nx;
  control_type   r_ctrl, w_ctrl_nx;
  control_type   r_ctrl_out, w_ctrl_out_nx;
  logic [31:0]   r_alu_out, w_alu_out_nx;
  logic [31:0]   r_mem_out, w_mem_out_nx;
`ifdef MISALIGN_TRAP_EN
  logic          r_fault, w_fault_nx;
`endif

  logic          w_mem_op;
  logic          w_complete;
  logic          w_stall;
  logic          w_req_valid;
  logic          w_bus_error;
  logic [3:0]    w_wstrb;
  logic [31:0]   w_wdata;
  logic [31:0]   w_load_data;

  assign w_mem_op = control_in.mem_read | control_in.mem_write;

  memory_access_stage_load_store_align u_load_store_align (
    .i_funct3     (r_f3),
    .i_offset     (r_addr[1:0]),
    .i_store_data (r_sdata),
    .i_load_word  (dmem_rdata),
    .o_wstrb      (w_wstrb),
    .o_wdata      (w_wdata),
    .o_load_data  (w_load_data)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_addr     <= '0;
      r_sdata    <= '0;
      r_f3       <= '0;
      r_ctrl     <= '0;
      r_ctrl_out <= '0;
      r_alu_out  <= '0;
      r_mem_out  <= '0;
`ifdef MISALIGN_TRAP_EN
      r_fault    <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nx;
      r_count    <= w_count_nx;
      r_addr     <= w_addr_nx;
      r_sdata    <= w_sdata_nx;
      r_f3       <= w_f3_nx;
      r_ctrl     <= w_ctrl_nx;
      r_ctrl_out <= w_ctrl_out_nx;
      r_alu_out  <= w_alu_out_nx;
      r_mem_out  <= w_mem_out_nx;
`ifdef MISALIGN_TRAP_EN
      r_fault    <= w_fault_nx;
`endif
    end
  end

  // Output register defaults to a bubble; only pass-through, completion,
  // timeout and trap cycles load real content.
  always_comb begin
    w_state_nx    = r_state;
    w_count_nx    = r_count;
    w_addr_nx     = r_addr;
    w_sdata_nx    = r_sdata;
    w_f3_nx       = r_f3;
    w_ctrl_nx     = r_ctrl;
    w_ctrl_out_nx = '0;
    w_alu_out_nx  = '0;
    w_mem_out_nx  = '0;
`ifdef MISALIGN_TRAP_EN
    w_fault_nx    = 1'b0;
`endif
    w_complete    = 1'b0;
    w_stall       = 1'b0;
    w_req_valid   = 1'b0;
    w_bus_error   = 1'b0;

    case (r_state)
      IDLE: begin
`ifdef MISALIGN_TRAP_EN
        if (w_mem_op && is_misaligned(funct3_in, alu_data_in[1:0])) begin
          w_ctrl_out_nx           = control_in;
          w_ctrl_out_nx.reg_write = 1'b0;
          w_alu_out_nx            = alu_data_in;
          w_fault_nx              = 1'b1;
        end else
`endif
        if (w_mem_op) begin
          w_stall    = 1'b1;
          w_addr_nx  = alu_data_in;
          w_sdata_nx = memory_data_in;
          w_f3_nx    = funct3_in;
          w_ctrl_nx  = control_in;
          w_state_nx = REQ;
        end else begin
          w_ctrl_out_nx = control_in;
          w_alu_out_nx  = alu_data_in;
        end
      end

      REQ: begin
        w_stall     = 1'b1;
        w_req_valid = 1'b1;
        if (dmem_req_ready) begin
          if (dmem_rsp_valid) begin
            w_complete = 1'b1;
          end else begin
            w_state_nx = WAIT;
            w_count_nx = '0;
          end
        end
      end

      WAIT: begin
        w_stall = 1'b1;
        if (dmem_rsp_valid) begin
          w_complete = 1'b1;
        end else if (r_count == MAX_WAIT_C) begin
          w_bus_error             = 1'b1;
          w_ctrl_out_nx           = r_ctrl;
          w_ctrl_out_nx.reg_write = 1'b0;
          w_alu_out_nx            = r_addr;
          w_state_nx              = IDLE;
        end else begin
          w_count_nx = r_count + 1'b1;
        end
      end

      default: w_state_nx = IDLE;
    endcase

    // mem_read wins when both read and write are set.
    if (w_complete) begin
      w_state_nx    = IDLE;
      w_ctrl_out_nx = r_ctrl;
      w_alu_out_nx  = r_addr;
      w_mem_out_nx  = r_ctrl.mem_read ? w_load_data : 32'd0;
    end
  end

  assign control_out     = r_ctrl_out;
  assign alu_data_out    = r_alu_out;
  assign memory_data_out = r_mem_out;
  assign stall           = w_stall;
  assign bus_error       = w_bus_error;
  assign dmem_req_valid  = w_req_valid;
  assign dmem_addr       = {r_addr[31:2], 2'b00};
  assign dmem_we         = ~r_ctrl.mem_read;
  assign dmem_wstrb      = dmem_we ? w_wstrb : 4'b0000;
  assign dmem_wdata      = w_wdata;
  assign o_dbg_state     = r_state;
`ifdef MISALIGN_TRAP_EN
  assign misaligned_fault = r_fault;
`endif

endmodule

// File: tb/tb_memory_access_stage.sv
// Self-checking bench for memory_access_stage: directed table, random
// accesses against an arithmetic reference model, timeout/reset/trap cases.
import memory_access_stage_pkg::*;

module tb_memory_access_stage;

  localparam int TB_MAX_WAIT = 4;

  logic          clk;
  logic          reset_n;
  logic [31:0]   alu_data_in;
  logic [31:0]   memory_data_in;
  logic [2:0]    funct3_in;
  control_type   control_in;
  control_type   control_out;
  logic [31:0]   alu_data_out;
  logic [31:0]   memory_data_out;
  logic          stall;
  logic          bus_error;
  logic          dmem_req_valid;
  logic          dmem_req_ready;
  logic [31:0]   dmem_addr;
  logic          dmem_we;
  logic [3:0]    dmem_wstrb;
  logic [31:0]   dmem_wdata;
  logic          dmem_rsp_valid;
  logic [31:0]   dmem_rdata;
`ifdef MISALIGN_TRAP_EN
  logic          misaligned_fault;
`endif
  mem_state_type dbg_state;

  memory_access_stage #(.MAX_WAIT(TB_MAX_WAIT)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .alu_data_in     (alu_data_in),
    .memory_data_in  (memory_data_in),
    .funct3_in       (funct3_in),
    .control_in      (control_in),
    .control_out     (control_out),
    .alu_data_out    (alu_data_out),
    .memory_data_out (memory_data_out),
    .stall           (stall),
    .bus_error       (bus_error),
    .dmem_req_valid  (dmem_req_valid),
    .dmem_req_ready  (dmem_req_ready),
    .dmem_addr       (dmem_addr),
    .dmem_we         (dmem_we),
    .dmem_wstrb      (dmem_wstrb),
    .dmem_wdata      (dmem_wdata),
    .dmem_rsp_valid  (dmem_rsp_valid),
    .dmem_rdata      (dmem_rdata),
`ifdef MISALIGN_TRAP_EN
    .misaligned_fault(misaligned_fault),
`endif
    .o_dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int unsigned acc_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  // Misaligned offsets round down to the access size.
  function automatic int unsigned eff_off(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned sz = acc_size(f3);
    int unsigned off = addr % 4;
    return off - (off % sz);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
    int unsigned    sz = acc_size(f3);
    longint unsigned v;
    v = (longint'(word) >> (8 * eff_off(f3, addr))) % (64'd1 << (8 * sz));
    if (!f3[2] && sz < 4 && v >= (64'd1 << (8 * sz - 1)))
      v = v + 64'h1_0000_0000 - (64'd1 << (8 * sz));
    return v[31:0];
  endfunction

  function automatic logic [3:0] model_wstrb(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned m = ((1 << acc_size(f3)) - 1) << eff_off(f3, addr);
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (acc_size(f3))
      1:       return (d % 256) * 32'h0101_0101;
      2:       return (d % 65536) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    control_in     = '0;
    alu_data_in    = 32'd0;
    memory_data_in = 32'd0;
    funct3_in      = 3'd0;
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    dmem_rdata     = 32'd0;
  endtask

  // Issues one access and plays the memory side: request accepted after
  // rdy_dly stalled cycles, response rsp_dly cycles after the handshake.
  task automatic do_access(input control_type c, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] sdata, input logic [31:0] rdata,
                           input int rdy_dly, input int rsp_dly, input logic [31:0] exp_out,
                           input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata);
    logic is_load = c.mem_read;
    exp_q.push_back(exp_out);
    @(negedge clk);
    control_in = c; alu_data_in = addr; memory_data_in = sdata; funct3_in = f3;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
    #1;
    check("issue_stall", 32'(stall), 32'd1);
    check("issue_no_req", 32'(dmem_req_valid), 32'd0);
    @(negedge clk);
    control_in = '0; alu_data_in = $urandom; memory_data_in = $urandom;
    funct3_in = 3'($urandom_range(0, 7));
    for (int i = 0; i <= rdy_dly; i++) begin
      #1;
      check("req_valid", 32'(dmem_req_valid), 32'd1);
      check("req_addr", dmem_addr, addr & 32'hFFFF_FFFC);
      check("req_we", 32'(dmem_we), 32'(!is_load));
      if (!is_load) begin
        check("req_wstrb", 32'(dmem_wstrb), 32'(exp_wstrb));
        check("req_wdata", dmem_wdata, exp_wdata);
      end
      if (i == rdy_dly) begin
        dmem_req_ready = 1'b1;
        if (rsp_dly == 0) begin
          dmem_rsp_valid = 1'b1;
          dmem_rdata     = rdata;
        end
      end
      @(negedge clk);
    end
    dmem_req_ready = 1'b0;
    for (int j = 1; j <= rsp_dly; j++) begin
      dmem_rdata = $urandom;
      #1;
      check("wait_stall", 32'(stall), 32'd1);
      check("wait_no_req", 32'(dmem_req_valid), 32'd0);
      if (j == rsp_dly) begin
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = rdata;
      end
      @(negedge clk);
    end
    dmem_rsp_valid = 1'b0;
    #1;
    check("done_stall", 32'(stall), 32'd0);
    check("done_ctrl", 32'(control_out), 32'(c));
    check("done_alu", alu_data_out, addr);
    check("done_mem", memory_data_out, exp_q.pop_front());
    check("done_state", 32'(dbg_state), 32'(IDLE));
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic        ld;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          rdy;
    int          rsp;
    logic [31:0] exp_out;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t        vecs[$];
  control_type ld_ctrl, st_ctrl, c, exp_c;
  logic [2:0]  ld_f3s[5];

  initial begin
    ld_ctrl = '{reg_write: 1'b1, mem_to_reg: 1'b1, mem_read: 1'b1, mem_write: 1'b0};
    st_ctrl = '{reg_write: 1'b0, mem_to_reg: 1'b0, mem_read: 1'b0, mem_write: 1'b1};
    ld_f3s  = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};

    vecs.push_back('{1'b0, F3_B,  32'h103, 32'h0000_00AB, 32'h0,         0, 1, 32'h0,         4'b1000, 32'hABAB_ABAB});
    vecs.push_back('{1'b1, F3_B,  32'h002, 32'h0,         32'h0080_0000, 0, 1, 32'hFFFF_FF80, 4'b0000, 32'h0});
    vecs.push_back('{1'b1, F3_BU, 32'h002, 32'h0,         32'h0080_0000, 1, 0, 32'h0000_0080, 4'b0000, 32'h0});
    vecs.push_back('{1'b1, F3_HU, 32'h002, 32'h0,         32'h0080_0000, 0, 2, 32'h0000_0080, 4'b0000, 32'h0});
    vecs.push_back('{1'b1, F3_H,  32'h000, 32'h0,         32'h0000_8001, 0, 0, 32'hFFFF_8001, 4'b0000, 32'h0});
    vecs.push_back('{1'b1, F3_W,  32'h010, 32'h0,         32'hDEAD_BEEF, 5, 1, 32'hDEAD_BEEF, 4'b0000, 32'h0});
    vecs.push_back('{1'b0, F3_H,  32'h022, 32'h1234_5678, 32'h0,         5, 3, 32'h0,         4'b1100, 32'h5678_5678});
    vecs.push_back('{1'b0, F3_W,  32'h030, 32'hCAFE_F00D, 32'h0,         0, 0, 32'h0,         4'b1111, 32'hCAFE_F00D});
    vecs.push_back('{1'b1, F3_B,  32'h001, 32'h0,         32'h0000_7F00, 2, 1, 32'h0000_007F, 4'b0000, 32'h0});
`ifndef MISALIGN_TRAP_EN
    vecs.push_back('{1'b1, F3_H,  32'h003, 32'h0,         32'hABCD_0000, 0, 1, 32'hFFFF_ABCD, 4'b0000, 32'h0});
    vecs.push_back('{1'b0, F3_H,  32'h041, 32'h0000_BEEF, 32'h0,         0, 1, 32'h0,         4'b0011, 32'hBEEF_BEEF});
`endif

    // Reset state
    drive_idle();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ctrl", 32'(control_out), 32'd0);
    check("rst_alu", alu_data_out, 32'd0);
    check("rst_mem", memory_data_out, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_req", 32'(dmem_req_valid), 32'd0);
    check("rst_buserr", 32'(bus_error), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    reset_n = 1'b1;

    // Non-memory pass-through
    @(negedge clk);
    c = '{reg_write: 1'b1, mem_to_reg: 1'b0, mem_read: 1'b0, mem_write: 1'b0};
    control_in = c; alu_data_in = 32'h1234;
    #1;
    check("alu_stall", 32'(stall), 32'd0);
    check("alu_no_req", 32'(dmem_req_valid), 32'd0);
    @(negedge clk);
    control_in = '0; alu_data_in = 32'h0;
    #1;
    check("alu_out", alu_data_out, 32'h1234);
    check("alu_ctrl", 32'(control_out), 32'(c));
    check("alu_memout", memory_data_out, 32'd0);
    check("alu_stall2", 32'(stall), 32'd0);

    // Directed table
    foreach (vecs[k])
      do_access(vecs[k].ld ? ld_ctrl : st_ctrl, vecs[k].f3, vecs[k].addr, vecs[k].sdata,
                vecs[k].rdata, vecs[k].rdy, vecs[k].rsp, vecs[k].exp_out,
                vecs[k].exp_wstrb, vecs[k].exp_wdata);

    // Random accesses against the reference model
    for (int n = 0; n < 40; n++) begin
      logic        ld;
      logic [2:0]  f3;
      logic [31:0] addr, sdata, rdata;
      ld = ($urandom_range(0, 1) == 1);
      f3 = ld ? ld_f3s[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
      addr = $urandom; sdata = $urandom; rdata = $urandom;
`ifdef MISALIGN_TRAP_EN
      addr = addr - (addr % acc_size(f3));
`endif
      c = ld ? ld_ctrl : st_ctrl;
      if (ld && $urandom_range(0, 3) == 0) c.mem_write = 1'b1;
      do_access(c, f3, addr, sdata, rdata, $urandom_range(0, 3), $urandom_range(0, 3),
                ld ? model_load(f3, addr, rdata) : 32'd0, model_wstrb(f3, addr),
                model_wdata(f3, sdata));
    end

    // Timeout: no response after the handshake
    @(negedge clk);
    control_in = ld_ctrl; alu_data_in = 32'h40; funct3_in = F3_W;
    @(negedge clk);
    control_in = '0; alu_data_in = 32'h0; dmem_req_ready = 1'b1;
    @(negedge clk);
    dmem_req_ready = 1'b0;
    for (int k = 1; k <= TB_MAX_WAIT + 1; k++) begin
      #1;
      check("to_buserr", 32'(bus_error), 32'(k == TB_MAX_WAIT + 1));
      check("to_stall", 32'(stall), 32'd1);
      @(negedge clk);
    end
    #1;
    exp_c = ld_ctrl;
    exp_c.reg_write = 1'b0;
    check("to_buserr_end", 32'(bus_error), 32'd0);
    check("to_ctrl", 32'(control_out), 32'(exp_c));
    check("to_regwrite", 32'(control_out.reg_write), 32'd0);
    check("to_alu", alu_data_out, 32'h40);
    check("to_state", 32'(dbg_state), 32'(IDLE));
    check("to_stall_end", 32'(stall), 32'd0);

    // Reset during WAIT, then a stray response
    @(negedge clk);
    control_in = ld_ctrl; alu_data_in = 32'h80; funct3_in = F3_W;
    @(negedge clk);
    control_in = '0; alu_data_in = 32'h0; dmem_req_ready = 1'b1;
    @(negedge clk);
    dmem_req_ready = 1'b0;
    #1;
    check("rw_in_wait", 32'(dbg_state), 32'(WAIT));
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rw_state", 32'(dbg_state), 32'(IDLE));
    check("rw_ctrl", 32'(control_out), 32'd0);
    dmem_rsp_valid = 1'b1; dmem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    dmem_rsp_valid = 1'b0;
    #1;
    check("stray_ctrl", 32'(control_out), 32'd0);
    check("stray_alu", alu_data_out, 32'd0);
    check("stray_mem", memory_data_out, 32'd0);
    check("stray_state", 32'(dbg_state), 32'(IDLE));
    check("stray_stall", 32'(stall), 32'd0);
    do_access(ld_ctrl, F3_W, 32'h84, 32'h0, 32'h1357_9BDF, 0, 1, 32'h1357_9BDF, 4'b0, 32'h0);

`ifdef MISALIGN_TRAP_EN
    // Misaligned word load traps without a request
    @(negedge clk);
    control_in = ld_ctrl; alu_data_in = 32'h6; funct3_in = F3_W;
    #1;
    check("trap_stall", 32'(stall), 32'd0);
    check("trap_no_req", 32'(dmem_req_valid), 32'd0);
    @(negedge clk);
    control_in = '0; alu_data_in = 32'h0;
    #1;
    check("trap_fault", 32'(misaligned_fault), 32'd1);
    check("trap_regwrite", 32'(control_out.reg_write), 32'd0);
    check("trap_state", 32'(dbg_state), 32'(IDLE));
    check("trap_no_req2", 32'(dmem_req_valid), 32'd0);
    @(negedge clk);
    #1;
    check("trap_fault_end", 32'(misaligned_fault), 32'd0);
`endif

    // Final report
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
